timer_countdown_bcd: RTL and testbench

Consumer side of the one-cycle tick interface produced by the clock divider. Holds a microwave cook time as four BCD digits (MM:SS) and decrements it by one second per tick while running. Reports completion with a one-cycle done pulse and feeds the digits to the display path. Sits between the divider/keypad encoder and the 7-segment drivers.

---
 rtl/timer_countdown_bcd.sv | 162 ++++++++++++++++
 tb/tb_timer_countdown_bcd.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown_bcd.sv
//============================================================================
// Module   : timer_countdown_bcd
// Purpose  : MM:SS BCD countdown driven by a 1 Hz tick strobe. Optional
//            TIMER_BLINK_EN macro adds a blink output toggled by ticks in DONE.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module timer_countdown_bcd #(
    parameter int MAX_MIN_TENS = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] din_min_t,
    input  logic [3:0] din_min_u,
    input  logic [3:0] din_sec_t,
    input  logic [3:0] din_sec_u,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done,
    output logic       load_err,
    output logic [1:0] state
`ifdef TIMER_BLINK_EN
    ,
    output logic       blink
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] w_min_t_nxt, w_min_u_nxt, w_sec_t_nxt, w_sec_u_nxt;
    logic [3:0] w_dec_min_t, w_dec_min_u, w_dec_sec_t, w_dec_sec_u;
    logic       w_b_sec_t, w_b_min_u, w_b_min_t;
    logic       w_done_nxt, w_err_nxt;
    logic       w_load_ok, w_zero, w_at_one;
`ifdef TIMER_BLINK_EN
    logic       w_blink_tick;
`endif

    assign w_load_ok = (din_min_t <= 4'(MAX_MIN_TENS)) && (din_min_t <= 4'd9) &&
                       (din_min_u <= 4'd9) && (din_sec_t <= 4'd5) && (din_sec_u <= 4'd9);
    assign w_zero    = (min_t == 4'd0) && (min_u == 4'd0) && (sec_t == 4'd0) && (sec_u == 4'd0);
    assign w_at_one  = (min_t == 4'd0) && (min_u == 4'd0) && (sec_t == 4'd0) && (sec_u == 4'd1);

    // Borrow ripples from seconds-units up to minutes-tens.
    assign w_b_sec_t   = (sec_u == 4'd0);
    assign w_b_min_u   = w_b_sec_t && (sec_t == 4'd0);
    assign w_b_min_t   = w_b_min_u && (min_u == 4'd0);
    assign w_dec_sec_u = (sec_u == 4'd0) ? 4'd9 : sec_u - 4'd1;
    assign w_dec_sec_t = !w_b_sec_t ? sec_t : ((sec_t == 4'd0) ? 4'd5 : sec_t - 4'd1);
    assign w_dec_min_u = !w_b_min_u ? min_u : ((min_u == 4'd0) ? 4'd9 : min_u - 4'd1);
    assign w_dec_min_t = w_b_min_t ? min_t - 4'd1 : min_t;

    always_comb begin
        w_state_nxt = r_state;
        w_min_t_nxt = min_t;
        w_min_u_nxt = min_u;
        w_sec_t_nxt = sec_t;
        w_sec_u_nxt = sec_u;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
`ifdef TIMER_BLINK_EN
        w_blink_tick = 1'b0;
`endif
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_min_t_nxt = 4'd0;
            w_min_u_nxt = 4'd0;
            w_sec_t_nxt = 4'd0;
            w_sec_u_nxt = 4'd0;
        end else if (load && r_state != S_RUN) begin
            if (w_load_ok) begin
                w_min_t_nxt = din_min_t;
                w_min_u_nxt = din_min_u;
                w_sec_t_nxt = din_sec_t;
                w_sec_u_nxt = din_sec_u;
                if (r_state == S_DONE) w_state_nxt = S_IDLE;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE, S_PAUSED: begin
                    if (start && !w_zero) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (tick && !w_zero) begin
                        w_min_t_nxt = w_dec_min_t;
                        w_min_u_nxt = w_dec_min_u;
                        w_sec_t_nxt = w_dec_sec_t;
                        w_sec_u_nxt = w_dec_sec_u;
                        if (w_at_one) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
`ifdef TIMER_BLINK_EN
                    w_blink_tick = tick;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            min_t    <= 4'd0;
            min_u    <= 4'd0;
            sec_t    <= 4'd0;
            sec_u    <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            min_t    <= w_min_t_nxt;
            min_u    <= w_min_u_nxt;
            sec_t    <= w_sec_t_nxt;
            sec_u    <= w_sec_u_nxt;
            running  <= (w_state_nxt == S_RUN);
            done     <= w_done_nxt;
            load_err <= w_err_nxt;
        end
    end

    assign state = r_state;

`ifdef TIMER_BLINK_EN
    // Blink only survives while staying in DONE; entering or leaving clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink <= 1'b0;
        end else if (r_state == S_DONE && w_state_nxt == S_DONE) begin
            blink <= blink ^ w_blink_tick;
        end else begin
            blink <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_countdown_bcd.sv
//============================================================================
// Module   : tb_timer_countdown_bcd
// Purpose  : Directed and random checks of timer_countdown_bcd against a
//            seconds-based reference model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_timer_countdown_bcd;

    localparam int MT = 5;

    logic       clock = 1'b0;
    logic       reset, tick, load, start, pause, clear;
    logic [3:0] din_min_t, din_min_u, din_sec_t, din_sec_u;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, done, load_err;
    logic [1:0] state;
    logic [3:0] z_min_t, z_min_u, z_sec_t, z_sec_u;
    logic       z_running, z_done, z_load_err;
    logic [1:0] z_state;
`ifdef TIMER_BLINK_EN
    logic       blink, z_blink;
`endif

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: time kept as total seconds.
    int m_secs  = 0;
    int m_state = 0;
    int m_done  = 0;
    int m_err   = 0;
    int m_blink = 0;

    always #5 clock = ~clock;

    timer_countdown_bcd #(.MAX_MIN_TENS(MT)) u_dut (
        .clock(clock), .reset(reset), .tick(tick), .load(load),
        .din_min_t(din_min_t), .din_min_u(din_min_u),
        .din_sec_t(din_sec_t), .din_sec_u(din_sec_u),
        .start(start), .pause(pause), .clear(clear),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .running(running), .done(done), .load_err(load_err), .state(state)
`ifdef TIMER_BLINK_EN
        , .blink(blink)
`endif
    );

    timer_countdown_bcd #(.MAX_MIN_TENS(0)) u_dut0 (
        .clock(clock), .reset(reset), .tick(tick), .load(load),
        .din_min_t(din_min_t), .din_min_u(din_min_u),
        .din_sec_t(din_sec_t), .din_sec_u(din_sec_u),
        .start(start), .pause(pause), .clear(clear),
        .min_t(z_min_t), .min_u(z_min_u), .sec_t(z_sec_t), .sec_u(z_sec_u),
        .running(z_running), .done(z_done), .load_err(z_load_err), .state(z_state)
`ifdef TIMER_BLINK_EN
        , .blink(z_blink)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic model_update();
        int prev, tk, v;
        logic ok;
        m_done = 0;
        m_err  = 0;
        if (reset) begin
            m_secs = 0; m_state = 0; m_blink = 0;
        end else begin
            prev = m_state;
            tk   = 0;
            ok   = (int'(din_min_t) <= MT) && (din_min_u <= 9) && (din_sec_t <= 5) && (din_sec_u <= 9);
            v    = (int'(din_min_t) * 10 + int'(din_min_u)) * 60 + int'(din_sec_t) * 10 + int'(din_sec_u);
            if (clear) begin
                m_secs = 0; m_state = 0;
            end else if (load && m_state != 1) begin
                if (ok) begin
                    m_secs = v;
                    if (m_state == 3) m_state = 0;
                end else begin
                    m_err = 1;
                end
            end else if (m_state == 0 || m_state == 2) begin
                if (start && m_secs > 0) m_state = 1;
            end else if (m_state == 1) begin
                if (pause) m_state = 2;
                else if (tick && m_secs > 0) begin
                    m_secs--;
                    if (m_secs == 0) begin
                        m_state = 3; m_done = 1;
                    end
                end
            end else begin
                tk = int'(tick);
            end
            m_blink = (prev == 3 && m_state == 3) ? (m_blink ^ tk) : 0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_value("digits",   {16'd0, min_t, min_u, sec_t, sec_u}, {16'd0, to_bcd(m_secs)});
        check_value("state",    {30'd0, state}, 32'(m_state));
        check_value("running",  {31'd0, running}, (m_state == 1) ? 32'd1 : 32'd0);
        check_value("done",     {31'd0, done}, 32'(m_done));
        check_value("load_err", {31'd0, load_err}, 32'(m_err));
        check_value("excl",     {31'd0, done & load_err}, 32'd0);
`ifdef TIMER_BLINK_EN
        check_value("blink",    {31'd0, blink}, 32'(m_blink));
`endif
        reset = 0; tick = 0; load = 0; start = 0; pause = 0; clear = 0;
    endtask

    task automatic do_load(input logic [3:0] a, b, c, d);
        din_min_t = a; din_min_u = b; din_sec_t = c; din_sec_u = d;
        load = 1;
        step();
    endtask

    function automatic logic [31:0] cur();
        return {16'd0, min_t, min_u, sec_t, sec_u};
    endfunction

    initial begin
        reset = 1; tick = 0; load = 0; start = 0; pause = 0; clear = 0;
        din_min_t = 0; din_min_u = 0; din_sec_t = 0; din_sec_u = 0;
        reset = 1; step();
        reset = 1; step();
        check_value("rst_digits", cur(), 32'h0);
        check_value("rst_state", {30'd0, state}, 32'd0);

        // 01:05 minus six seconds
        do_load(4'd0, 4'd1, 4'd0, 4'd5);
        start = 1; step();
        for (int i = 0; i < 6; i++) begin
            tick = 1; step();
            check_value("t1_running", {31'd0, running}, 32'd1);
            for (int j = 0; j < 139; j++) step();
        end
        check_value("t1_digits", cur(), 32'h0059);

        // completion
        clear = 1; step();
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        start = 1; step();
        tick = 1; step();
        step();
        tick = 1; step();
        check_value("t2_digits", cur(), 32'h0);
        check_value("t2_state", {30'd0, state}, 32'd3);
        check_value("t2_running", {31'd0, running}, 32'd0);
        check_value("t2_done", {31'd0, done}, 32'd1);
        step();
        check_value("t2_done_off", {31'd0, done}, 32'd0);
`ifdef TIMER_BLINK_EN
        check_value("bl_entry", {31'd0, blink}, 32'd0);
        tick = 1; step(); check_value("bl_1", {31'd0, blink}, 32'd1);
        tick = 1; step(); check_value("bl_2", {31'd0, blink}, 32'd0);
        tick = 1; step(); check_value("bl_3", {31'd0, blink}, 32'd1);
`endif
        tick = 1; step();
        check_value("t2_hold", cur(), 32'h0);
        check_value("t2_nodone", {31'd0, done}, 32'd0);
        clear = 1; step();
`ifdef TIMER_BLINK_EN
        check_value("bl_clear", {31'd0, blink}, 32'd0);
`endif
        check_value("t2_clear_state", {30'd0, state}, 32'd0);

        // pause and tick together
        do_load(4'd0, 4'd0, 4'd3, 4'd1);
        start = 1; step();
        tick = 1; step();
        pause = 1; tick = 1; step();
        check_value("t3_hold", cur(), 32'h0030);
        check_value("t3_state", {30'd0, state}, 32'd2);
        for (int i = 0; i < 5; i++) begin tick = 1; step(); end
        check_value("t3_paused", cur(), 32'h0030);
        start = 1; step();
        tick = 1; step();
        check_value("t3_resume", cur(), 32'h0029);

        // load validation
        clear = 1; step();
        do_load(4'd0, 4'd2, 4'd0, 4'd0);
        do_load(4'd0, 4'd0, 4'd7, 4'd5);
        check_value("t4_err", {31'd0, load_err}, 32'd1);
        check_value("t4_keep", cur(), 32'h0200);
        step();
        check_value("t4_err_off", {31'd0, load_err}, 32'd0);
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        check_value("t4_max0_err", {31'd0, z_load_err}, 32'd1);
        check_value("t4_max5_ok", cur(), 32'h1000);
        do_load(4'd6, 4'd0, 4'd0, 4'd0);
        check_value("t4_max5_err", {31'd0, load_err}, 32'd1);

        // reset mid-run
        do_load(4'd0, 4'd3, 4'd1, 4'd0);
        start = 1; step();
        reset = 1; tick = 1; step();
        check_value("t5_digits", cur(), 32'h0);
        check_value("t5_state", {30'd0, state}, 32'd0);
        start = 1; step();
        check_value("t5_start0", {30'd0, state}, 32'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            int act;
            act = int'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) reset = 1;
            case (act)
                0: clear = 1;
                1, 2: begin
                    load = 1;
                    if ($urandom_range(0, 3) == 0) begin
                        din_min_t = 4'($urandom); din_min_u = 4'($urandom);
                        din_sec_t = 4'($urandom); din_sec_u = 4'($urandom);
                    end else begin
                        din_min_t = 0; din_min_u = 4'($urandom_range(0, 1));
                        din_sec_t = 4'($urandom_range(0, 1)); din_sec_u = 4'($urandom_range(0, 9));
                    end
                end
                3: begin pause = 1; tick = 1'($urandom); end
                4, 5, 6: start = 1;
                default: tick = 1'($urandom);
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
